// File: rtl/gate_bist_2in_pkg.sv
// Shared types and constants for the 2-input gate BIST driver.
package gate_bist_2in_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned FC_W  = 3;
    localparam int unsigned TT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [TT_W-1:0] TT_AND  = 4'b1000;
    localparam logic [TT_W-1:0] TT_NAND = 4'b0111;
    localparam logic [TT_W-1:0] TT_OR   = 4'b1110;
    localparam logic [TT_W-1:0] TT_NOR  = 4'b0001;
    localparam logic [TT_W-1:0] TT_XOR  = 4'b0110;
    localparam logic [TT_W-1:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_settle_ctr.sv
// Loadable down-counter timing how long each vector settles before sampling.
module gate_bist_settle_ctr
    import gate_bist_2in_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != CNT_W'(0))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last APPLY cycle is the one where the counter still shows 1.
    assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/gate_bist_2in.sv
// Sweeps {a,b} through 00..11, samples a gate under test after a settle time
// and reports pass/fail, mismatch count, mask and first failing vector.
module gate_bist_2in
    import gate_bist_2in_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    input  logic            gate_out,
    output logic            a,
    output logic            b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [FC_W-1:0] fail_count,
    output logic [TT_W-1:0] fail_mask,
    output logic [VEC_W-1:0] first_fail
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [TT_W-1:0]    exp_q, exp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic [TT_W-1:0]    fm_q, fm_d;
    logic [VEC_W-1:0]   ff_q, ff_d;
    logic               ctr_load_c;
    logic               ctr_en_c;
    logic               ctr_last_c;
    logic               mismatch_c;

    gate_bist_settle_ctr u_settle_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load_c),
        .en       (ctr_en_c),
        .load_val (CNT_W'(SETTLE_CYCLES)),
        .last_c   (ctr_last_c)
    );

    // Case-inequality so an X/Z gate output is reported as a mismatch.
    assign mismatch_c = (gate_out !== exp_q[vec_q]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fc_d       = fc_q;
        fm_d       = fm_q;
        ff_d       = ff_q;
        ctr_load_c = 1'b0;
        ctr_en_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d      = expected;
                    vec_d      = '0;
                    pass_d     = 1'b0;
                    fc_d       = '0;
                    fm_d       = '0;
                    ff_d       = '0;
                    busy_d     = 1'b1;
                    ctr_load_c = 1'b1;
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                ctr_en_c = 1'b1;
                if (ctr_last_c) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    fm_d[vec_q] = 1'b1;
                    fc_d        = fc_q + FC_W'(1);
                    if (fc_q == FC_W'(0)) begin
                        ff_d = vec_q;
                    end
                end
                // pass is resolved here so it is valid alongside the done pulse.
                if (vec_q == VEC_W'(3)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fm_d == TT_W'(0));
                    state_d = ST_DONE;
                end else begin
                    vec_d      = vec_q + VEC_W'(1);
                    ctr_load_c = 1'b1;
                    state_d    = ST_APPLY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= '0;
            fm_q    <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            fm_q    <= fm_d;
            ff_q    <= ff_d;
        end
    end

    assign a          = vec_q[1];
    assign b          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fc_q;
    assign fail_mask  = fm_q;
    assign first_fail = ff_q;

endmodule
